tel_frame_reader: RTL and testbench

TEL_FRAME_READER -- requirements
Module: tel_frame_reader

---
 rtl/tel_pkg.sv | 25 ++
 rtl/tel_chksum.sv | 41 ++++
 rtl/tel_frame_reader.sv | 174 +++++++++++++++++
 tb/tb_tel_frame_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tel_pkg
//  Purpose  : Shared constants and FSM state encoding for tel_frame_reader.
//  Revision : 1.0 - initial release
// ============================================================================
package tel_pkg;

    localparam logic [7:0]  TEL_FIRST_ADDR = 8'h02;
    localparam logic [7:0]  TEL_LAST_ADDR  = 8'h24;
    localparam logic [15:0] TEL_HDR_WORD   = 16'hEB90;

    typedef logic [2:0] tel_state_t;

    localparam tel_state_t ST_IDLE  = 3'd0;
    localparam tel_state_t ST_STORE = 3'd1;
    localparam tel_state_t ST_HDR   = 3'd2;
    localparam tel_state_t ST_CNT   = 3'd3;
    localparam tel_state_t ST_RD    = 3'd4;
    localparam tel_state_t ST_CAP   = 3'd5;
    localparam tel_state_t ST_SEND  = 3'd6;
    localparam tel_state_t ST_CHK   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/tel_chksum.sv
`default_nettype none
// ============================================================================
//  Module   : tel_chksum
//  Purpose  : 16-bit modulo-2^16 running sum with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module tel_chksum
    import tel_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clr_in,
    input  logic        add_en_in,
    input  logic [15:0] data_in,
    output logic [15:0] sum_out
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_in) begin
            sum_d = 16'h0000;
        end else if (add_en_in) begin
            sum_d = sum_q + data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_out = sum_q;

endmodule
`default_nettype wire

// File: rtl/tel_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tel_frame_reader
//  Purpose  : Snapshots the monitor bank and streams header, frame count and
//             monitor words (plus checksum when TEL_CHKSUM_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tel_frame_reader
    import tel_pkg::*;
#(
    parameter logic [7:0]  FIRST_ADDR = TEL_FIRST_ADDR,
    parameter logic [7:0]  LAST_ADDR  = TEL_LAST_ADDR,
    parameter logic [15:0] HDR_WORD   = TEL_HDR_WORD
)(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tel_req_in,
    output logic        store_en_out,
    output logic        rd_out,
    output logic [7:0]  rd_addr_out,
    input  logic [15:0] mon_data_in,
    output logic [15:0] tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    output logic        busy_out,
    output logic [15:0] frame_cnt_out
);

    tel_state_t  state_q;
    tel_state_t  state_d;
    logic [7:0]  addr_q;
    logic [7:0]  addr_d;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;
    logic        tx_hs;

    assign tx_hs = tx_valid_out && tx_ready_in;

`ifdef TEL_CHKSUM_EN
    // Sum covers the count word and every captured monitor word.
    logic        chk_clr;
    logic        chk_add;
    logic [15:0] chk_data;
    logic [15:0] chk_sum;

    assign chk_clr  = (state_q == ST_STORE);
    assign chk_add  = (state_q == ST_CAP) || ((state_q == ST_CNT) && tx_hs);
    assign chk_data = (state_q == ST_CAP) ? mon_data_in : frame_cnt_q;

    tel_chksum u_chksum (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (chk_clr),
        .add_en_in (chk_add),
        .data_in   (chk_data),
        .sum_out   (chk_sum)
    );
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tel_req_in) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                addr_d  = FIRST_ADDR;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                if (tx_hs) begin
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (tx_hs) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                data_d  = mon_data_in;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_hs) begin
                    if (addr_q == LAST_ADDR) begin
`ifdef TEL_CHKSUM_EN
                        state_d     = ST_CHK;
`else
                        state_d     = ST_IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
`endif
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = ST_RD;
                    end
                end
            end
`ifdef TEL_CHKSUM_EN
            ST_CHK: begin
                if (tx_hs) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            addr_q      <= 8'h00;
            data_q      <= 16'h0000;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Word presented is a pure function of state, so it cannot move mid-stall.
    always_comb begin
        tx_data_out  = 16'h0000;
        tx_valid_out = 1'b0;
        case (state_q)
            ST_HDR: begin
                tx_data_out  = HDR_WORD;
                tx_valid_out = 1'b1;
            end
            ST_CNT: begin
                tx_data_out  = frame_cnt_q;
                tx_valid_out = 1'b1;
            end
            ST_SEND: begin
                tx_data_out  = data_q;
                tx_valid_out = 1'b1;
            end
`ifdef TEL_CHKSUM_EN
            ST_CHK: begin
                tx_data_out  = chk_sum;
                tx_valid_out = 1'b1;
            end
`endif
            default: begin
                tx_data_out  = 16'h0000;
                tx_valid_out = 1'b0;
            end
        endcase
    end

    assign store_en_out  = (state_q == ST_STORE);
    assign rd_out        = (state_q == ST_RD);
    assign rd_addr_out   = addr_q;
    assign busy_out      = (state_q != ST_IDLE);
    assign frame_cnt_out = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tel_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tel_frame_reader
//  Purpose  : Self-checking bench for tel_frame_reader (TEL_CHKSUM_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tel_frame_reader;

    localparam logic [7:0]  FIRST = 8'h02;
    localparam logic [7:0]  LAST  = 8'h24;
    localparam logic [15:0] HDR   = 16'hEB90;
    localparam int          NDATA = 35;
`ifdef TEL_CHKSUM_EN
    localparam int          NWORDS = NDATA + 3;
`else
    localparam int          NWORDS = NDATA + 2;
`endif

    logic        clk_in      = 1'b0;
    logic        rst_in      = 1'b0;
    logic        tel_req_in  = 1'b0;
    logic        tx_ready_in = 1'b0;
    logic [15:0] mon_data_in = 16'h0000;
    logic        store_en_out;
    logic        rd_out;
    logic [7:0]  rd_addr_out;
    logic [15:0] tx_data_out;
    logic        tx_valid_out;
    logic        busy_out;
    logic [15:0] frame_cnt_out;

    always #10 clk_in = ~clk_in;

    tel_frame_reader dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .tel_req_in    (tel_req_in),
        .store_en_out  (store_en_out),
        .rd_out        (rd_out),
        .rd_addr_out   (rd_addr_out),
        .mon_data_in   (mon_data_in),
        .tx_data_out   (tx_data_out),
        .tx_valid_out  (tx_valid_out),
        .tx_ready_in   (tx_ready_in),
        .busy_out      (busy_out),
        .frame_cnt_out (frame_cnt_out)
    );

    // Monitor bank model: read data valid only in the cycle after rd_out.
    always @(posedge clk_in) begin
        mon_data_in <= rd_out ? {rd_addr_out, rd_addr_out} : 16'hDEAD;
    end

    int          store_cycles = 0;
    int          overlap      = 0;
    int          stab_err     = 0;
    int          hs_cnt       = 0;
    int          rd_cnt [256];
    logic        last_v       = 1'b0;
    logic [15:0] last_d       = 16'h0000;

    always begin
        @(posedge clk_in);
        #1;
        if (!rst_in) begin
            last_v <= 1'b0;
        end else begin
            if (store_en_out)           store_cycles <= store_cycles + 1;
            if (rd_out)                 rd_cnt[rd_addr_out] <= rd_cnt[rd_addr_out] + 1;
            if (rd_out && store_en_out) overlap <= overlap + 1;
            if (last_v && tx_ready_in)  hs_cnt <= hs_cnt + 1;
            if (last_v && !tx_ready_in && !(tx_valid_out && tx_data_out == last_d))
                stab_err <= stab_err + 1;
            last_v <= tx_valid_out;
            last_d <= tx_data_out;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          stall;
    } vec_t;

    vec_t tbl [NWORDS];

    task automatic build_table(input logic [15:0] cnt, input bit rnd);
        logic [15:0] sum;
        logic [7:0]  a;
        tbl[0].word = HDR;
        tbl[1].word = cnt;
        sum = cnt;
        for (int i = 0; i < NDATA; i++) begin
            a = FIRST + 8'(i);
            tbl[2 + i].word = {a, a};
            sum = sum + {a, a};
        end
`ifdef TEL_CHKSUM_EN
        tbl[NWORDS - 1].word = sum;
`endif
        for (int i = 0; i < NWORDS; i++) begin
            tbl[i].stall = rnd ? int'($urandom_range(0, 3)) : 0;
        end
    endtask

    task automatic get_word(input int stall, input bit req, output logic [15:0] w);
        int t;
        t = 0;
        if (stall > 0) tx_ready_in = 1'b0;
        while (!tx_valid_out && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        if (!tx_valid_out) begin
            check("valid_timeout", 32'd0, 32'd1);
            w = 16'h0000;
        end else begin
            w = tx_data_out;
            for (int s = 0; s < stall; s++) @(negedge clk_in);
            tx_ready_in = 1'b1;
            tel_req_in  = req;
            @(negedge clk_in);
            tel_req_in  = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input int n_words, input int req_at);
        int          rd_snap [256];
        int          st_snap;
        int          hs_snap;
        int          bad;
        int          total;
        logic [15:0] w;
        rd_snap = rd_cnt;
        st_snap = store_cycles;
        hs_snap = hs_cnt;
        tel_req_in = 1'b1;
        @(negedge clk_in);
        tel_req_in = 1'b0;
        check({tag, "_store_en"}, 32'(store_en_out), 32'd1);
        check({tag, "_busy_hi"}, 32'(busy_out), 32'd1);
        for (int i = 0; i < n_words; i++) begin
            get_word(tbl[i].stall, (i == req_at), w);
            check($sformatf("%s_word%0d", tag, i), 32'(w), 32'(tbl[i].word));
        end
        if (n_words == NWORDS) begin
            bad   = 0;
            total = 0;
            for (int a = 0; a < 256; a++) begin
                total += rd_cnt[a] - rd_snap[a];
                if (a >= int'(FIRST) && a <= int'(LAST) && rd_cnt[a] - rd_snap[a] != 1) bad++;
            end
            check({tag, "_busy_lo"}, 32'(busy_out), 32'd0);
            check({tag, "_store_cycles"}, 32'(store_cycles - st_snap), 32'd1);
            check({tag, "_rd_per_addr_bad"}, 32'(bad), 32'd0);
            check({tag, "_rd_total"}, 32'(total), 32'(NDATA));
            check({tag, "_handshakes"}, 32'(hs_cnt - hs_snap), 32'(NWORDS));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_store_en"}, 32'(store_en_out), 32'd0);
        check({tag, "_rd"}, 32'(rd_out), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr_out), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data_out), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid_out), 32'd0);
        check({tag, "_busy"}, 32'(busy_out), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) rd_cnt[a] = 0;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_in = 1'b1;
        @(negedge clk_in);

        // Full frame with continuous ready.
        build_table(16'h0000, 1'b0);
        tx_ready_in = 1'b1;
        run_frame("f1", NWORDS, -1);
        check("f1_frame_cnt", 32'(frame_cnt_out), 32'd1);

        // Random back-pressure plus a request while busy at word 10.
        build_table(16'h0001, 1'b1);
        run_frame("f2", NWORDS, 10);
        repeat (5) @(negedge clk_in);
        check("f2_idle_after", 32'(busy_out), 32'd0);
        check("f2_frame_cnt", 32'(frame_cnt_out), 32'd2);

        // Request in the same cycle as the final handshake is dropped.
        build_table(16'h0002, 1'b1);
        run_frame("f3", NWORDS, NWORDS - 1);
        repeat (3) @(negedge clk_in);
        check("f3_req_ignored_busy", 32'(busy_out), 32'd0);
        check("f3_req_ignored_valid", 32'(tx_valid_out), 32'd0);
        check("f3_frame_cnt", 32'(frame_cnt_out), 32'd3);

        // Reset mid-frame at word 20.
        build_table(16'h0003, 1'b0);
        run_frame("f4", 20, -1);
        rst_in = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        build_table(16'h0000, 1'b1);
        run_frame("f5", NWORDS, -1);
        check("f5_frame_cnt", 32'(frame_cnt_out), 32'd1);

        // Frame counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        repeat (2) @(negedge clk_in);
        release dut.frame_cnt_q;
        @(negedge clk_in);
        check("wrap_preload", 32'(frame_cnt_out), 32'h0000FFFF);
        build_table(16'hFFFF, 1'b0);
        tx_ready_in = 1'b1;
        run_frame("f6", NWORDS, -1);
        check("f6_frame_cnt_wrap", 32'(frame_cnt_out), 32'd0);

        check("stall_stability", 32'(stab_err), 32'd0);
        check("rd_store_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
